// File: rtl/otter_cu_pkg.sv
// Shared state encoding and RV32I opcode constants for the OTTER control unit and decoder.
package otter_cu_pkg;

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_EXEC      = 3'd2,
    ST_LOAD_WAIT = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_INTR      = 3'd5
  } cu_state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_MRET    = 3'b000;
  localparam logic [2:0] F3_SYS_RSV = 3'b100;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cu_fsm_mc_if.sv
// Instruction-field inputs and datapath enable strobes between the control unit and the datapath.
interface cu_fsm_mc_if;
  logic [6:0] ir6_0;
  logic [2:0] ir14_12;
  logic       intr;
  logic       csr_mie;
  logic       PCWrite;
  logic       regWrite;
  logic       memWE2;
  logic       memRDEN1;
  logic       memRDEN2;
  logic       reset;
  logic       csr_WE;
  logic       int_taken;
  logic       mret_exec;

  // Enables are level strobes, one cycle per write; there is no valid/ready handshake.
  modport master (
    input  ir6_0, ir14_12, intr, csr_mie,
    output PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset, csr_WE, int_taken, mret_exec
  );

  modport slave (
    output ir6_0, ir14_12, intr, csr_mie,
    input  PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset, csr_WE, int_taken, mret_exec
  );
endinterface

// File: rtl/cu_fsm_mc.sv
// Multicycle OTTER control unit: init hold, fetch/load wait states, interrupt entry, CSR/mret decode.
module cu_fsm_mc
  import otter_cu_pkg::*;
#(
  parameter int INIT_CYCLES = 1,
  parameter int FETCH_WAIT  = 0,
  parameter int LOAD_WAIT   = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  cu_fsm_mc_if.master       bus,
  output cu_state_t         state_o
);

  localparam int CNT_MAX = max3(INIT_CYCLES, FETCH_WAIT + 1, LOAD_WAIT + 1);
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] INIT_LAST  = CW'(INIT_CYCLES - 1);
  localparam logic [CW-1:0] FETCH_LAST = CW'(FETCH_WAIT);
  localparam logic [CW-1:0] LOAD_LAST  = CW'((LOAD_WAIT > 0) ? LOAD_WAIT - 1 : 0);

  cu_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          intr_pend;
  logic          is_load;

  logic pc_write, reg_write, mem_we2, mem_rden1, mem_rden2, rst_out, csr_we, int_tkn, mret_x;

  assign intr_pend = bus.intr & bus.csr_mie;
  assign is_load   = (bus.ir6_0 == OP_LOAD);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:      if (cnt_q == INIT_LAST) state_d = ST_FETCH;
      ST_FETCH:     if (cnt_q == FETCH_LAST) state_d = ST_EXEC;
      ST_EXEC: begin
        if (is_load) state_d = (LOAD_WAIT > 0) ? ST_LOAD_WAIT : ST_WRITEBACK;
        else         state_d = intr_pend ? ST_INTR : ST_FETCH;
      end
      ST_LOAD_WAIT: if (cnt_q == LOAD_LAST) state_d = ST_WRITEBACK;
      ST_WRITEBACK: state_d = intr_pend ? ST_INTR : ST_FETCH;
      ST_INTR:      state_d = ST_FETCH;
      default:      state_d = ST_INIT;
    endcase
  end

  // The counter restarts on every state change, so each wait state counts from zero.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? '0 : cnt_q + CW'(1);
    end
  end

  always_comb begin
    pc_write  = 1'b0;
    reg_write = 1'b0;
    mem_we2   = 1'b0;
    mem_rden1 = 1'b0;
    mem_rden2 = 1'b0;
    rst_out   = 1'b0;
    csr_we    = 1'b0;
    int_tkn   = 1'b0;
    mret_x    = 1'b0;
    case (state_q)
      ST_INIT:  rst_out   = 1'b1;
      ST_FETCH: mem_rden1 = 1'b1;
      ST_EXEC: begin
        case (bus.ir6_0)
          OP_RTYPE, OP_ITYPE, OP_JALR, OP_LUI, OP_AUIPC, OP_JAL: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
          end
          OP_STORE: begin
            mem_we2  = 1'b1;
            pc_write = 1'b1;
          end
          OP_BRANCH: pc_write  = 1'b1;
          OP_LOAD:   mem_rden2 = 1'b1;
          OP_SYSTEM: begin
            pc_write = 1'b1;
            if (bus.ir14_12 == F3_MRET) begin
              mret_x = 1'b1;
            end else if (bus.ir14_12 != F3_SYS_RSV) begin
              csr_we    = 1'b1;
              reg_write = 1'b1;
            end
          end
          // Illegal opcodes only advance the PC so the instruction is skipped.
          default: pc_write = 1'b1;
        endcase
      end
      ST_LOAD_WAIT: mem_rden2 = 1'b1;
      ST_WRITEBACK: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
      end
      ST_INTR: begin
        int_tkn  = 1'b1;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.PCWrite   = pc_write;
  assign bus.regWrite  = reg_write;
  assign bus.memWE2    = mem_we2;
  assign bus.memRDEN1  = mem_rden1;
  assign bus.memRDEN2  = mem_rden2;
  assign bus.reset     = rst_out;
  assign bus.csr_WE    = csr_we;
  assign bus.int_taken = int_tkn;
  assign bus.mret_exec = mret_x;
  assign state_o       = state_q;

endmodule

// File: tb/tb_cu_fsm_mc.sv
// Bench for cu_fsm_mc: two configurations, per-instruction expected cycle sequences from an opcode model.
module tb_cu_fsm_mc;
  import otter_cu_pkg::*;

  localparam int A_INIT = 1, A_FW = 0, A_LW = 0;
  localparam int B_INIT = 4, B_FW = 2, B_LW = 3;

  // Bit positions in the observed output word.
  localparam int B_PC = 8, B_RW = 7, B_WE = 6, B_RD1 = 5, B_RD2 = 4;
  localparam int B_RST = 3, B_CSR = 2, B_INT = 1, B_MRET = 0;

  localparam logic [6:0] T_R = 7'b0110011, T_I = 7'b0010011, T_LD = 7'b0000011;
  localparam logic [6:0] T_ST = 7'b0100011, T_BR = 7'b1100011, T_JAL = 7'b1101111;
  localparam logic [6:0] T_JALR = 7'b1100111, T_LUI = 7'b0110111, T_AUI = 7'b0010111;
  localparam logic [6:0] T_SYS = 7'b1110011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_a, rst_n_b;
  logic [6:0] ir;
  logic [2:0] f3;
  logic       intr, mie;
  logic       sel;
  int         init_c, fw, lw;
  int         checks, errors;
  logic [8:0] exp_q[$];
  logic [8:0] obs_a, obs_b, obs;
  cu_state_t  st_a, st_b;

  cu_fsm_mc_if if_a();
  cu_fsm_mc_if if_b();

  cu_fsm_mc u_dut_a (.CLK(clk), .RST_N(rst_n_a), .bus(if_a.master), .state_o(st_a));
  cu_fsm_mc #(.INIT_CYCLES(B_INIT), .FETCH_WAIT(B_FW), .LOAD_WAIT(B_LW))
    u_dut_b (.CLK(clk), .RST_N(rst_n_b), .bus(if_b.master), .state_o(st_b));

  assign if_a.ir6_0 = ir;  assign if_a.ir14_12 = f3;  assign if_a.intr = intr;  assign if_a.csr_mie = mie;
  assign if_b.ir6_0 = ir;  assign if_b.ir14_12 = f3;  assign if_b.intr = intr;  assign if_b.csr_mie = mie;

  assign obs_a = {if_a.PCWrite, if_a.regWrite, if_a.memWE2, if_a.memRDEN1, if_a.memRDEN2,
                  if_a.reset, if_a.csr_WE, if_a.int_taken, if_a.mret_exec};
  assign obs_b = {if_b.PCWrite, if_b.regWrite, if_b.memWE2, if_b.memRDEN1, if_b.memRDEN2,
                  if_b.reset, if_b.csr_WE, if_b.int_taken, if_b.mret_exec};
  assign obs   = sel ? obs_b : obs_a;

  function automatic logic [8:0] bitw(input int b);
    return 9'(1) << b;
  endfunction

  // Output word for the single execute cycle of an instruction.
  function automatic logic [8:0] exec_word(input logic [6:0] op, input logic [2:0] fn);
    logic [8:0] w;
    w = bitw(B_PC);
    if (op inside {T_R, T_I, T_JALR, T_LUI, T_AUI, T_JAL}) w = w | bitw(B_RW);
    else if (op == T_ST)                w = w | bitw(B_WE);
    else if (op == T_LD)                w = bitw(B_RD2);
    else if (op == T_SYS && fn == 3'b000) w = w | bitw(B_MRET);
    else if (op == T_SYS && fn != 3'b100) w = w | bitw(B_CSR) | bitw(B_RW);
    return w;
  endfunction

  // Whole-instruction cycle sequence; intr rises at cycle ia and is honoured only at the boundary.
  task automatic build_seq(input logic [6:0] op, input logic [2:0] fn, input logic iv,
                           input logic mv, input int ia);
    int bnd;
    repeat (fw + 1) exp_q.push_back(bitw(B_RD1));
    exp_q.push_back(exec_word(op, fn));
    if (op == T_LD) begin
      repeat (lw) exp_q.push_back(bitw(B_RD2));
      exp_q.push_back(bitw(B_RW) | bitw(B_PC));
      bnd = fw + lw + 2;
    end else begin
      bnd = fw + 1;
    end
    if (iv && mv && ia <= bnd) exp_q.push_back(bitw(B_INT) | bitw(B_PC));
  endtask

  task automatic select_dut(input logic s);
    sel    = s;
    init_c = s ? B_INIT : A_INIT;
    fw     = s ? B_FW : A_FW;
    lw     = s ? B_LW : A_LW;
  endtask

  task automatic set_rst(input logic v);
    if (sel) rst_n_b = v;
    else     rst_n_a = v;
  endtask

  // Holds reset low for n_low edges, then checks the init hold until the first fetch.
  task automatic do_reset(input int n_low);
    set_rst(1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < n_low - 1; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== bitw(B_RST)) begin
        errors++;
        $display("FAIL reset_low dut%0d cyc %0d got %b exp %b", sel, i, obs, bitw(B_RST));
      end
      @(posedge clk); #1;
    end
    set_rst(1'b1);
    for (int i = 0; i < init_c; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== bitw(B_RST)) begin
        errors++;
        $display("FAIL init_hold dut%0d cyc %0d got %b exp %b", sel, i, obs, bitw(B_RST));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] fn,
                           input logic iv, input logic mv, input int ia);
    logic [8:0] e;
    int n;
    exp_q.delete();
    build_seq(op, fn, iv, mv, ia);
    n   = exp_q.size();
    ir  = op;
    f3  = fn;
    mie = mv;
    for (int k = 0; k < n; k++) begin
      intr = (k >= ia) ? iv : 1'b0;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s dut%0d op %b f3 %b cyc %0d got %b exp %b", name, sel, op, fn, k, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    select_dut(1'b0);
    do_reset(3);
    run_instr("rtype_first", T_R, 3'b000, 1'b0, 1'b0, 0);
    run_instr("rtype_second", T_R, 3'b000, 1'b0, 1'b0, 0);
  endtask

  task automatic test_load_wait();
    select_dut(1'b1);
    do_reset(2);
    run_instr("load_wait", T_LD, 3'b010, 1'b0, 1'b0, 0);
    run_instr("store_after_load", T_ST, 3'b010, 1'b0, 1'b0, 0);
    select_dut(1'b0);
    do_reset(1);
    run_instr("load_nowait", T_LD, 3'b010, 1'b0, 1'b0, 0);
  endtask

  task automatic test_interrupt();
    select_dut(1'b1);
    do_reset(1);
    run_instr("intr_store", T_ST, 3'b010, 1'b1, 1'b1, 1);
    run_instr("intr_masked", T_ST, 3'b010, 1'b1, 1'b0, 0);
    run_instr("intr_deferred_load", T_LD, 3'b000, 1'b1, 1'b1, B_FW + 2);
    run_instr("intr_branch", T_BR, 3'b001, 1'b1, 1'b1, 0);
    select_dut(1'b0);
    do_reset(1);
    run_instr("intr_store_a", T_ST, 3'b010, 1'b1, 1'b1, 0);
    run_instr("intr_late", T_R, 3'b000, 1'b1, 1'b1, 2);
  endtask

  task automatic test_system();
    select_dut(1'b0);
    do_reset(1);
    run_instr("mret", T_SYS, 3'b000, 1'b1, 1'b0, 0);
    run_instr("csrrw", T_SYS, 3'b001, 1'b0, 1'b0, 0);
    run_instr("csrrci", T_SYS, 3'b111, 1'b0, 1'b0, 0);
    run_instr("sys_f3_100", T_SYS, 3'b100, 1'b0, 1'b0, 0);
  endtask

  task automatic test_reset_mid_load();
    logic [8:0] e;
    select_dut(1'b1);
    do_reset(1);
    exp_q.delete();
    build_seq(T_LD, 3'b010, 1'b0, 1'b0, 0);
    ir   = T_LD;
    f3   = 3'b010;
    intr = 1'b0;
    mie  = 1'b0;
    // Stop one cycle into the load wait and pull reset.
    for (int k = 0; k < B_FW + 3; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL abort_prefix dut%0d cyc %0d got %b exp %b", sel, k, obs, e);
      end
      @(posedge clk); #1;
    end
    exp_q.delete();
    do_reset(1);
    run_instr("after_abort", T_I, 3'b000, 1'b0, 1'b0, 0);
  endtask

  task automatic test_illegal_init();
    select_dut(1'b1);
    do_reset(2);
    run_instr("illegal_op", 7'b1111111, 3'b000, 1'b0, 1'b0, 0);
    run_instr("jal_after_illegal", T_JAL, 3'b000, 1'b0, 1'b0, 0);
  endtask

  task automatic test_random();
    logic [6:0] ops[10];
    logic [6:0] op;
    int idx;
    ops = '{T_R, T_I, T_LD, T_ST, T_BR, T_JAL, T_JALR, T_LUI, T_AUI, T_SYS};
    for (int d = 0; d < 2; d++) begin
      select_dut(d[0]);
      do_reset(1);
      for (int n = 0; n < 40; n++) begin
        idx = $urandom_range(0, 11);
        op  = (idx < 10) ? ops[idx] : 7'($urandom_range(0, 127));
        run_instr("random", op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 8));
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    ir      = 7'd0;
    f3      = 3'd0;
    intr    = 1'b0;
    mie     = 1'b0;
    select_dut(1'b0);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load_wait();
    test_interrupt();
    test_system();
    test_reset_mid_load();
    test_illegal_init();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cu_fsm_mc.md
Name: cu_fsm_mc

Overview:
Multicycle control unit FSM for the OTTER MCU, successor to the fixed four-state controller. Adds parametrised fetch/load wait states for slower memories, a multi-cycle reset hold, a machine-interrupt entry state, and CSR-write and mret decoding for the SYSTEM opcode. It sits between the instruction register (opcode/funct3) and the datapath enables (PC, register file, memory, CSR file).

Parameters:
INIT_CYCLES, 1, cycles the reset output is held in ST_INIT (>=1)
FETCH_WAIT, 0, extra cycles memRDEN1 is held after the first fetch cycle (0..15)
LOAD_WAIT, 0, extra cycles memRDEN2 is held after the EXEC cycle of a load (0..15)

Ports:
CLK  input  1  system clock, all state on rising edge
RST_N  input  1  synchronous active-low reset
ir6_0  input  7  instruction opcode
ir14_12  input  3  instruction funct3
intr  input  1  level-sensitive external interrupt request
csr_mie  input  1  MSTATUS.MIE from the CSR file; interrupts honoured only when 1
PCWrite  output  1  PC register load enable
regWrite  output  1  register file write enable
memWE2  output  1  data memory write enable
memRDEN1  output  1  instruction memory read enable
memRDEN2  output  1  data memory read enable
reset  output  1  PC/datapath reset
csr_WE  output  1  CSR file write enable
int_taken  output  1  interrupt entry (CSR file saves mepc, clears MIE; PC mux selects mtvec)
mret_exec  output  1  mret executing (CSR file restores MIE; PC mux selects mepc)

Behaviour:
- Outputs are combinational from state, wait count and inputs; every output defaults to 0 unless listed below.
- RST_N=0 at a rising edge: state goes to ST_INIT and the wait counter goes to 0. This also applies mid-instruction, and any wait in progress is discarded.
- A single wait counter is sized to $clog2(max(INIT_CYCLES, FETCH_WAIT+1, LOAD_WAIT+1)+1) bits. It is cleared on every state change.
- ST_INIT: reset=1. Stays until the counter reaches INIT_CYCLES-1, then goes to ST_FETCH.
- ST_FETCH: memRDEN1=1. Stays until the counter reaches FETCH_WAIT, then goes to ST_EXEC. With FETCH_WAIT=0 the latency is 1 cycle.
- ST_EXEC, decoded by ir6_0:
  - 0110011 (R), 0010011 (I), 1100111 (jalr), 0110111 (lui), 0010111 (auipc), 1101111 (jal): regWrite=1, PCWrite=1.
  - 0100011 (store): memWE2=1, PCWrite=1.
  - 1100011 (branch): PCWrite=1.
  - 0000011 (load): memRDEN2=1, PCWrite=0. Next state is ST_LOAD_WAIT if LOAD_WAIT>0, else ST_WRITEBACK.
  - 1110011 with funct3=000: mret_exec=1, PCWrite=1.
  - 1110011 with funct3 in 001/010/011/101/110/111 (CSR ops): csr_WE=1, regWrite=1, PCWrite=1.
  - 1110011 with funct3=100, or any other opcode (illegal): PCWrite=1 only, so the instruction is skipped.
  - Non-load next state: ST_INTR if (intr & csr_mie), else ST_FETCH.
  - mret: csr_mie is sampled before restore, so an interrupt pending during mret is taken only after the next instruction.
- ST_LOAD_WAIT: memRDEN2=1. Stays until the counter reaches LOAD_WAIT-1, then goes to ST_WRITEBACK.
- ST_WRITEBACK: regWrite=1, PCWrite=1. Next state is ST_INTR if (intr & csr_mie), else ST_FETCH.
- ST_INTR: int_taken=1, PCWrite=1. Lasts exactly 1 cycle, then ST_FETCH.
  - The interrupt is never re-taken from ST_INTR. Re-entry relies on the CSR file clearing MIE.
- Interrupts are checked only at instruction boundaries (end of EXEC for non-loads, end of WRITEBACK). intr asserted during FETCH or LOAD_WAIT is deferred, not lost, provided it is still high at the boundary.
- An illegal encoding of the state register decodes as ST_INIT with all outputs 0.
- No output is ever asserted in two states for the same write. Each instruction produces exactly one PCWrite pulse, plus one more if an interrupt is taken.

Decomposition:
- Package otter_cu_pkg:
  - typedef enum logic [2:0] cu_state_t {ST_INIT, ST_FETCH, ST_EXEC, ST_LOAD_WAIT, ST_WRITEBACK, ST_INTR}.
  - localparam opcode constants: OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM.
  - localparam F3_MRET = 3'b000.
- Shared with the decoder.
- No sub-module: the wait counter stays inline.

Test Plan:
- Defaults, RST_N low 3 cycles then high, ir6_0=0110011 -> reset=1 for 1 cycle, memRDEN1 for 1 cycle, then regWrite=PCWrite=1 for 1 cycle; period 2 cycles per instruction.
- FETCH_WAIT=2, LOAD_WAIT=3, ir6_0=0000011 -> memRDEN1 high 3 cycles, memRDEN2 high 4 cycles (EXEC+3), then one WRITEBACK cycle with regWrite=PCWrite=1; total 8 cycles.
- intr=1, csr_mie=1 raised during FETCH of a store -> EXEC memWE2=PCWrite=1, next cycle int_taken=PCWrite=1, then memRDEN1; with csr_mie=0 int_taken never asserts.
- ir6_0=1110011: funct3=000 -> mret_exec=1, csr_WE=0; funct3=001 -> csr_WE=regWrite=PCWrite=1; funct3=100 -> PCWrite only.
- RST_N driven low during ST_LOAD_WAIT (LOAD_WAIT=3) -> next cycle reset=1, memRDEN2=0, no regWrite pulse for the aborted load.
- INIT_CYCLES=4 -> reset held exactly 4 cycles after RST_N rises; illegal opcode 7'b1111111 -> one PCWrite pulse, no regWrite/memWE2/csr_WE.
